// File: rtl/tieoff_gate.sv
// Run-time tie-off for NCH valid/ready channels: pass-through or a safe constant,
// switched only on packet boundaries so consumers never see a truncated packet.

module tieoff_lane #(
  parameter int          W       = 4,
  parameter logic [W-1:0] TIE    = '0,
  parameter bit          DISCARD = 1'b0
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         srcValid,
  input  logic [W-1:0] srcData,
  input  logic         srcLast,
  output logic         srcReady,
  output logic         outValid,
  output logic [W-1:0] outData,
  input  logic         outReady,
  input  logic         tieReq,
  output logic         tieAck,
  output logic         nextTied
);
  typedef enum logic [1:0] {LIVE, DRAIN, TIED} state_t;

  state_t state, nextState;
  logic   inPkt, nextInPkt, accept, tied;

  assign tied     = (state == TIED);
  assign srcReady = tied ? DISCARD : outReady;
  assign outValid = tied ? 1'b0 : srcValid;
  assign outData  = tied ? TIE : srcData;
  assign accept   = srcValid && srcReady;
  assign nextInPkt = accept ? !srcLast : inPkt;

  // A withdrawn request wins over draining; a tied channel with an open discarded
  // packet keeps dropping until its last beat so nothing partial leaks out.
  always_comb begin
    nextState = state;
    unique case (state)
      LIVE:    if (tieReq) nextState = nextInPkt ? DRAIN : TIED;
      DRAIN:   if (!tieReq) nextState = LIVE;
               else if (!nextInPkt) nextState = TIED;
      TIED:    if (!tieReq && !nextInPkt) nextState = LIVE;
      default: nextState = TIED;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= TIED;
      inPkt <= 1'b0;
    end else begin
      state <= nextState;
      inPkt <= nextInPkt;
    end
  end

  assign tieAck   = tied;
  assign nextTied = (nextState == TIED);
endmodule

module tieoff_gate #(
  parameter int                 NCH             = 4,
  parameter int                 W               = 4,
  parameter logic [NCH*W-1:0]   TIE_VALUE       = {NCH*W{1'b0}},
  parameter logic [NCH-1:0]     ACTIVE_LOW_MASK = {NCH{1'b0}},
  parameter logic [NCH-1:0]     DISCARD_MASK    = {NCH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [NCH-1:0]             src_valid,
  input  logic [NCH*W-1:0]           src_data,
  input  logic [NCH-1:0]             src_last,
  output logic [NCH-1:0]             src_ready,
  output logic [NCH-1:0]             out_valid,
  output logic [NCH*W-1:0]           out_data,
  input  logic [NCH-1:0]             out_ready,
  input  logic [NCH-1:0]             tie_req,
  output logic [NCH-1:0]             tie_ack,
  output logic [$clog2(NCH+1)-1:0]   tied_count
);
  localparam int CW = $clog2(NCH+1);

  logic [NCH-1:0] nextTied;
  logic [CW-1:0]  nextCount;

  for (genvar i = 0; i < NCH; i++) begin : gLane
    localparam logic [W-1:0] TV = ACTIVE_LOW_MASK[i] ? {W{1'b1}} : TIE_VALUE[i*W +: W];
    tieoff_lane #(.W(W), .TIE(TV), .DISCARD(DISCARD_MASK[i])) uLane (
      .clk      (clk),
      .rstN     (reset_l),
      .srcValid (src_valid[i]),
      .srcData  (src_data[i*W +: W]),
      .srcLast  (src_last[i]),
      .srcReady (src_ready[i]),
      .outValid (out_valid[i]),
      .outData  (out_data[i*W +: W]),
      .outReady (out_ready[i]),
      .tieReq   (tie_req[i]),
      .tieAck   (tie_ack[i]),
      .nextTied (nextTied[i])
    );
  end

  always_comb begin
    nextCount = '0;
    for (int i = 0; i < NCH; i++) nextCount = nextCount + CW'(nextTied[i]);
  end

  // Count is registered from next-state so it moves on the same edge as tie_ack.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) tied_count <= CW'(NCH);
    else          tied_count <= nextCount;
  end
endmodule

// File: tb/tb_tieoff_gate.sv
// Directed bench for tieoff_gate: expected output beats are queued per channel
// and popped by a negedge monitor; control outputs are checked directly.

module tb_tieoff_gate;
  localparam int NCH = 4;
  localparam int W   = 4;

  logic              clk = 1'b0;
  logic              reset_l;
  logic [NCH-1:0]    src_valid, src_last, src_ready, out_valid, out_ready, tie_req, tie_ack;
  logic [NCH*W-1:0]  src_data, out_data;
  logic [2:0]        tied_count;

  int nCmp = 0;
  int nErr = 0;
  logic [W-1:0] expQ [NCH][$];

  tieoff_gate #(
    .NCH(NCH), .W(W), .TIE_VALUE(16'h0000),
    .ACTIVE_LOW_MASK(4'b1000), .DISCARD_MASK(4'b0010)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tie_req(tie_req), .tie_ack(tie_ack), .tied_count(tied_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int ch, input logic [W-1:0] d, input logic last, input bit expect_out);
    src_valid[ch] = 1'b1;
    src_data[ch*W +: W] = d;
    src_last[ch] = last;
    if (expect_out) expQ[ch].push_back(d);
  endtask

  // Monitor: every transfer seen downstream must match the head of its queue.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (out_valid[c] === 1'b1 && out_ready[c] === 1'b1) begin
        nCmp++;
        if (expQ[c].size() == 0) begin
          nErr++;
          $display("FAIL beat_ch%0d: got unexpected beat %0h expected none", c, out_data[c*W +: W]);
        end else begin
          logic [W-1:0] e;
          e = expQ[c].pop_front();
          if (out_data[c*W +: W] !== e) begin
            nErr++;
            $display("FAIL beat_ch%0d: got %0h expected %0h", c, out_data[c*W +: W], e);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b1; src_valid = '0; src_last = '0; out_ready = '1; tie_req = '0;
    src_data = 16'h1234;
    #2 reset_l = 1'b0;
    #1;
    check("rst_out_data",   32'(out_data),   32'hF000);
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_tie_ack",    32'(tie_ack),    32'hF);
    check("rst_tied_count", 32'(tied_count), 32'd4);
    check("rst_src_ready",  32'(src_ready),  32'b0010);
    tick(); tick();
    reset_l = 1'b1;
    tick();
    check("rel_tie_ack",    32'(tie_ack),    32'h0);
    check("rel_tied_count", 32'(tied_count), 32'd0);
    beat(0, 4'h5, 1'b1, 1'b1);
    tick();
    src_valid = '0;

    // ch0 idle tie-off
    tie_req[0] = 1'b1;
    tick();
    src_data[3:0] = 4'hA; src_valid[0] = 1'b1;
    #1;
    check("ch0_tie_ack",    32'(tie_ack),       32'b0001);
    check("ch0_out_data",   32'(out_data[3:0]), 32'h0);
    check("ch0_src_ready",  32'(src_ready[0]),  32'h0);
    check("ch0_out_valid",  32'(out_valid[0]),  32'h0);
    check("ch0_tied_count", 32'(tied_count),    32'd1);
    src_valid[0] = 1'b0;

    // ch2 drains an open packet before tying
    beat(2, 4'h1, 1'b0, 1'b1);
    tick();
    tie_req[2] = 1'b1;
    beat(2, 4'h2, 1'b0, 1'b1);
    tick();
    check("ch2_drain_ack", 32'(tie_ack[2]), 32'h0);
    beat(2, 4'h3, 1'b1, 1'b1);
    out_ready[2] = 1'b0;
    repeat (3) tick();
    check("ch2_stall_valid", 32'(out_valid[2]), 32'h1);
    check("ch2_stall_ready", 32'(src_ready[2]), 32'h0);
    check("ch2_stall_ack",   32'(tie_ack[2]),   32'h0);
    out_ready[2] = 1'b1;
    tick();
    src_valid[2] = 1'b0; src_data[11:8] = 4'h7;
    #1;
    check("ch2_tied_ack",   32'(tie_ack),         32'b0101);
    check("ch2_tied_count", 32'(tied_count),      32'd2);
    check("ch2_tie_data",   32'(out_data[11:8]),  32'h0);

    // ch1 discard: release arrives mid discarded packet
    tie_req[1] = 1'b1;
    tick();
    check("ch1_tied_ack",   32'(tie_ack[1]),   32'h1);
    check("ch1_discard_rdy", 32'(src_ready[1]), 32'h1);
    beat(1, 4'h9, 1'b0, 1'b0);
    tick();
    tie_req[1] = 1'b0; src_valid[1] = 1'b0;
    tick();
    check("ch1_hold_tied", 32'(tie_ack[1]), 32'h1);
    beat(1, 4'hA, 1'b1, 1'b0);
    #1;
    check("ch1_drop_valid", 32'(out_valid[1]), 32'h0);
    tick();
    check("ch1_live_ack", 32'(tie_ack[1]), 32'h0);
    beat(1, 4'hB, 1'b0, 1'b1);
    tick();
    beat(1, 4'hC, 1'b1, 1'b1);
    tick();
    src_valid[1] = 1'b0;

    // ch3 active-low tie, then a withdrawn request during drain
    tie_req[3] = 1'b1;
    tick();
    src_data[15:12] = 4'h3;
    #1;
    check("ch3_tie_data", 32'(out_data[15:12]), 32'hF);
    tie_req[3] = 1'b0;
    tick();
    check("ch3_live_ack", 32'(tie_ack[3]), 32'h0);
    beat(3, 4'h4, 1'b0, 1'b1);
    tick();
    tie_req[3] = 1'b1;
    beat(3, 4'h5, 1'b0, 1'b1);
    tick();
    tie_req[3] = 1'b0; src_valid[3] = 1'b0;
    tick();
    beat(3, 4'h6, 1'b1, 1'b1);
    tick();
    src_valid[3] = 1'b0;
    check("ch3_after_ack", 32'(tie_ack[3]), 32'h0);

    // ch2 async reset mid-packet
    tie_req[2] = 1'b0;
    tick();
    check("ch2_rel_ack", 32'(tie_ack[2]), 32'h0);
    beat(2, 4'h8, 1'b0, 1'b1);
    tick();
    src_valid[2] = 1'b0;
    reset_l = 1'b0;
    #1;
    check("arst_tie_ack",    32'(tie_ack),    32'hF);
    check("arst_tied_count", 32'(tied_count), 32'd4);
    check("arst_out_valid",  32'(out_valid),  32'h0);
    tick();
    reset_l = 1'b1;
    tick();
    check("arst_rel_ack", 32'(tie_ack), 32'b0001);
    beat(2, 4'hB, 1'b0, 1'b1);
    tick();
    beat(2, 4'hC, 1'b1, 1'b1);
    tick();
    src_valid = '0;
    repeat (2) tick();

    for (int c = 0; c < NCH; c++) check($sformatf("drain_q%0d", c), 32'(expQ[c].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
